// File: rtl/alarm_bank.sv
// Multi-channel alarm engine: N_ALARM hour/minute alarms compared on the 1 Hz enable,
// with ack, bounded snooze, auto-stop and a blinking LED bus.

module alarm_chan #(
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3,
  parameter int RING_SEC   = 60,
  parameter int SCW        = 9,
  parameter int SNW        = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk1sec,
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic [7:0] second,
  input  logic       wr_sel,
  input  logic [7:0] wr_hour,
  input  logic [7:0] wr_min,
  input  logic       wr_arm,
  input  logic       ack_sel,
  input  logic       snz_sel,
  output logic       ringing_nxt,
  output logic       arm_nxt
);
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} st_e;

  localparam logic [7:0]     RS   = 8'(RING_SEC);
  localparam logic [SCW-1:0] SL   = SCW'(SNOOZE_MIN * 60);
  localparam logic [SNW-1:0] MAXS = SNW'(MAX_SNOOZE);

  st_e            st_q, st_d;
  logic [7:0]     hour_q, hour_d, min_q, min_d, ring_cnt_q, ring_cnt_d;
  logic           arm_q, arm_d;
  logic [SCW-1:0] snz_cnt_q, snz_cnt_d;
  logic [SNW-1:0] snz_num_q, snz_num_d;

  // Priority: write > ack/snooze > per-second timing/trigger.
  always_comb begin
    st_d       = st_q;
    hour_d     = hour_q;
    min_d      = min_q;
    arm_d      = arm_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    snz_num_d  = snz_num_q;
    if (wr_sel) begin
      hour_d     = wr_hour;
      min_d      = wr_min;
      arm_d      = wr_arm;
      st_d       = IDLE;
      ring_cnt_d = '0;
      snz_cnt_d  = '0;
      snz_num_d  = '0;
    end else if (st_q == RINGING && (ack_sel || snz_sel)) begin
      if (ack_sel || snz_num_q == MAXS) begin
        st_d = IDLE;
      end else begin
        st_d      = SNOOZED;
        snz_cnt_d = SL;
        snz_num_d = snz_num_q + 1'b1;
      end
    end else if (clk1sec) begin
      unique case (st_q)
        IDLE: if (arm_q && second == 8'd0 && hour == hour_q && minute == min_q) begin
          st_d       = RINGING;
          ring_cnt_d = '0;
          snz_num_d  = '0;
        end
        RINGING: begin
          ring_cnt_d = ring_cnt_q + 8'd1;
          if (ring_cnt_d == RS) st_d = IDLE;
        end
        SNOOZED: begin
          snz_cnt_d = snz_cnt_q - 1'b1;
          if (snz_cnt_d == '0) begin
            st_d       = RINGING;
            ring_cnt_d = '0;
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q       <= IDLE;
      hour_q     <= '0;
      min_q      <= '0;
      arm_q      <= 1'b0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      snz_num_q  <= '0;
    end else begin
      st_q       <= st_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      arm_q      <= arm_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      snz_num_q  <= snz_num_d;
    end
  end

  // Next-state views let the top register its outputs with one cycle of latency.
  assign ringing_nxt = (st_d == RINGING);
  assign arm_nxt     = arm_d;
endmodule

module alarm_bank #(
  parameter int N_ALARM    = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3,
  parameter int RING_SEC   = 60,
  parameter int LED_W      = 8,
  localparam int IW        = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk1sec,
  input  logic [7:0]         hour,
  input  logic [7:0]         minute,
  input  logic [7:0]         second,
  input  logic               wr_en,
  input  logic [IW-1:0]      wr_idx,
  input  logic [7:0]         wr_hour,
  input  logic [7:0]         wr_min,
  input  logic               wr_arm,
  input  logic               ack,
  input  logic               snooze,
  output logic               ring,
  output logic [IW-1:0]      ring_idx,
  output logic [N_ALARM-1:0] armed,
  output logic [LED_W-1:0]   led
);
  localparam int SCW = $clog2(SNOOZE_MIN * 60 + 1);
  localparam int SNW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  logic [N_ALARM-1:0] wr_sel, ack_sel, snz_sel, rng_nxt, arm_nxt;
  logic               ring_q, ring_d, phase_q, phase_d;
  logic [IW-1:0]      ring_idx_q, ring_idx_d;
  logic [N_ALARM-1:0] armed_q, armed_d;
  logic [LED_W-1:0]   led_q, led_d;

  // An out-of-range wr_idx matches no lane and is dropped.
  always_comb begin
    for (int i = 0; i < N_ALARM; i++) begin
      wr_sel[i]  = wr_en  && (wr_idx == IW'(i));
      ack_sel[i] = ack    && (ring_idx_q == IW'(i));
      snz_sel[i] = snooze && (ring_idx_q == IW'(i));
    end
  end

  for (genvar g = 0; g < N_ALARM; g++) begin : g_ch
    alarm_chan #(
      .SNOOZE_MIN(SNOOZE_MIN), .MAX_SNOOZE(MAX_SNOOZE), .RING_SEC(RING_SEC),
      .SCW(SCW), .SNW(SNW)
    ) u_ch (
      .clk(clk), .rst(rst), .clk1sec(clk1sec),
      .hour(hour), .minute(minute), .second(second),
      .wr_sel(wr_sel[g]), .wr_hour(wr_hour), .wr_min(wr_min), .wr_arm(wr_arm),
      .ack_sel(ack_sel[g]), .snz_sel(snz_sel[g]),
      .ringing_nxt(rng_nxt[g]), .arm_nxt(arm_nxt[g])
    );
  end

  always_comb begin
    ring_d     = |rng_nxt;
    ring_idx_d = '0;
    for (int i = N_ALARM - 1; i >= 0; i--)
      if (rng_nxt[i]) ring_idx_d = IW'(i);
    armed_d = arm_nxt;
    // Phase only advances on seconds where the ring was already showing.
    phase_d = ring_d ? (phase_q ^ (clk1sec & ring_q)) : 1'b0;
    led_d   = {LED_W{phase_d}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ring_q     <= 1'b0;
      ring_idx_q <= '0;
      armed_q    <= '0;
      phase_q    <= 1'b0;
      led_q      <= '0;
    end else begin
      ring_q     <= ring_d;
      ring_idx_q <= ring_idx_d;
      armed_q    <= armed_d;
      phase_q    <= phase_d;
      led_q      <= led_d;
    end
  end

  assign ring     = ring_q;
  assign ring_idx = ring_idx_q;
  assign armed    = armed_q;
  assign led      = led_q;
endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank: timestamp-based reference model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.

module tb_alarm_bank;
  localparam int N = 4, SMIN = 1, MAXS = 3, RSEC = 60, LW = 8, IW = 2;

  logic clk = 0, rst = 0, clk1sec = 0, wr_en = 0, wr_arm = 0, ack = 0, snooze = 0;
  logic [7:0] hour = 0, minute = 0, second = 0, wr_hour = 0, wr_min = 0;
  logic [IW-1:0] wr_idx = 0;
  logic ring;
  logic [IW-1:0] ring_idx;
  logic [N-1:0] armed;
  logic [LW-1:0] led;

  int checks = 0, errors = 0;

  alarm_bank #(.N_ALARM(N), .SNOOZE_MIN(SMIN), .MAX_SNOOZE(MAXS), .RING_SEC(RSEC), .LED_W(LW)) dut (
    .clk(clk), .rst(rst), .clk1sec(clk1sec), .hour(hour), .minute(minute), .second(second),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_hour(wr_hour), .wr_min(wr_min), .wr_arm(wr_arm),
    .ack(ack), .snooze(snooze), .ring(ring), .ring_idx(ring_idx), .armed(armed), .led(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state 0=idle 1=ringing 2=snoozed; times kept as absolute pulse numbers.
  int m_st[N], m_start[N], m_wake[N], m_snz[N], m_h[N], m_m[N];
  bit m_arm[N];
  int pulses = 0, m_idx = 0;
  bit m_ring = 0, m_phase = 0;

  task automatic model_clear();
    for (int c = 0; c < N; c++) begin
      m_st[c] = 0; m_start[c] = 0; m_wake[c] = 0; m_snz[c] = 0;
      m_h[c] = 0; m_m[c] = 0; m_arm[c] = 0;
    end
    m_ring = 0; m_idx = 0; m_phase = 0;
  endtask

  task automatic model_step();
    int now, nidx;
    bit any;
    now = pulses + (clk1sec ? 1 : 0);
    for (int c = 0; c < N; c++) begin
      if (wr_en && wr_idx == c) begin
        m_h[c] = wr_hour; m_m[c] = wr_min; m_arm[c] = wr_arm; m_st[c] = 0; m_snz[c] = 0;
      end else if (m_st[c] == 1 && m_idx == c && (ack || snooze)) begin
        if (ack || m_snz[c] == MAXS) m_st[c] = 0;
        else begin m_st[c] = 2; m_snz[c]++; m_wake[c] = now + SMIN * 60; end
      end else if (clk1sec) begin
        if (m_st[c] == 1 && now - m_start[c] == RSEC) m_st[c] = 0;
        else if (m_st[c] == 2 && now == m_wake[c]) begin m_st[c] = 1; m_start[c] = now; end
        else if (m_st[c] == 0 && m_arm[c] && second == 0 && hour == m_h[c] && minute == m_m[c]) begin
          m_st[c] = 1; m_start[c] = now; m_snz[c] = 0;
        end
      end
    end
    pulses = now;
    any = 0; nidx = 0;
    for (int c = N - 1; c >= 0; c--) if (m_st[c] == 1) begin any = 1; nidx = c; end
    if (!any) m_phase = 0;
    else if (clk1sec && m_ring) m_phase = !m_phase;
    m_ring = any;
    m_idx = nidx;
  endtask

  always @(posedge clk) begin
    if (!rst) model_clear();
    else model_step();
    #1;
    chk("cyc_ring", ring, m_ring);
    chk("cyc_ring_idx", ring_idx, m_ring ? m_idx : 0);
    chk("cyc_armed", armed, {m_arm[3], m_arm[2], m_arm[1], m_arm[0]});
    chk("cyc_led", led, m_phase ? 8'hFF : 8'h00);
  end

  // Stimulus helpers: inputs change on negedge; each returns on the negedge after the active posedge.
  task automatic adv_time();
    if (second == 59) begin
      second = 0;
      if (minute == 59) begin minute = 0; hour = (hour == 23) ? 8'd0 : hour + 8'd1; end
      else minute++;
    end else second++;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    @(negedge clk); hour = 8'(h); minute = 8'(m); second = 8'(s);
  endtask

  task automatic sec_tick();
    @(negedge clk); adv_time(); clk1sec = 1;
    @(negedge clk); clk1sec = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) sec_tick();
  endtask

  task automatic write(input int idx, input int h, input int m, input bit a);
    @(negedge clk); wr_en = 1; wr_idx = IW'(idx); wr_hour = 8'(h); wr_min = 8'(m); wr_arm = a;
    @(negedge clk); wr_en = 0;
  endtask

  task automatic pulse(input bit a, input bit s);
    @(negedge clk); ack = a; snooze = s;
    @(negedge clk); ack = 0; snooze = 0;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_ring", ring, 0); chk("rst_idx", ring_idx, 0);
    chk("rst_armed", armed, 0); chk("rst_led", led, 0);
    @(negedge clk); rst = 1;

    // basic trigger on ch1 at 07:30
    write(1, 7, 30, 1);
    chk("armed_ch1", armed, 4'b0010);
    set_time(7, 29, 58);
    sec_tick(); chk("pre_trig_ring", ring, 0);
    sec_tick(); chk("trig_ring", ring, 1); chk("trig_idx", ring_idx, 1); chk("trig_led", led, 8'h00);
    sec_tick(); chk("blink_on", led, 8'hFF); chk("still_ring", ring, 1);
    pulse(1, 0); chk("ack_ring", ring, 0); chk("ack_led", led, 0);
    sec_tick(); chk("no_retrig", ring, 0); chk("armed_kept", armed, 4'b0010);

    // auto-stop on ch0 with blink check each pulse
    write(0, 8, 0, 1);
    set_time(7, 59, 59);
    sec_tick(); chk("as_trig", ring, 1); chk("as_idx", ring_idx, 0);
    for (int k = 1; k < RSEC; k++) begin
      sec_tick();
      chk("as_ring", ring, 1);
      chk("as_led", led, (k % 2) ? 8'hFF : 8'h00);
    end
    sec_tick(); chk("as_stop", ring, 0); chk("as_led_off", led, 0); chk("as_armed", armed, 4'b0011);

    // snooze three times, fourth acts as ack
    write(2, 9, 0, 1);
    set_time(8, 59, 59);
    sec_tick(); chk("sz_trig", ring, 1); chk("sz_idx", ring_idx, 2);
    for (int s = 0; s < 3; s++) begin
      pulse(0, 1); chk("sz_off", ring, 0);
      ticks(59); chk("sz_quiet", ring, 0);
      sec_tick(); chk("sz_rering", ring, 1); chk("sz_rering_idx", ring_idx, 2);
    end
    pulse(0, 1); chk("sz4_off", ring, 0);
    ticks(70); chk("sz4_no_rering", ring, 0);

    // two channels at 12:00: priority and successive acks
    write(0, 12, 0, 1);
    write(3, 12, 0, 1);
    set_time(11, 59, 59);
    sec_tick(); chk("pr_ring", ring, 1); chk("pr_idx0", ring_idx, 0);
    pulse(1, 0); chk("pr_ring_on", ring, 1); chk("pr_idx3", ring_idx, 3);
    pulse(1, 0); chk("pr_off", ring, 0);

    // write colliding with trigger on ch1
    write(1, 13, 0, 1);
    set_time(12, 59, 59);
    @(negedge clk); adv_time(); clk1sec = 1;
    wr_en = 1; wr_idx = 1; wr_hour = 13; wr_min = 0; wr_arm = 1;
    @(negedge clk); clk1sec = 0; wr_en = 0;
    chk("wr_wins", ring, 0);

    // ack and snooze together: ack wins, no re-ring after a snooze length
    write(1, 14, 0, 1);
    set_time(13, 59, 59);
    sec_tick(); chk("as2_trig", ring, 1); chk("as2_idx", ring_idx, 1);
    pulse(1, 1); chk("as2_off", ring, 0);
    ticks(61); chk("as2_no_snooze", ring, 0);

    // async reset while snoozed
    write(3, 15, 0, 1);
    set_time(14, 59, 59);
    sec_tick(); chk("rs_trig", ring, 1); chk("rs_idx", ring_idx, 3);
    pulse(0, 1); chk("rs_snoozed", ring, 0); chk("rs_armed_pre", armed, 4'b1111);
    ticks(5);
    @(negedge clk); #2 rst = 0;
    #1 chk("rs_armed_now", armed, 0); chk("rs_ring_now", ring, 0); chk("rs_led_now", led, 0);
    @(negedge clk); rst = 1;
    ticks(65); chk("rs_no_ring", ring, 0);
    set_time(14, 59, 59);
    sec_tick(); chk("rs_unarmed", ring, 0); chk("rs_armed_post", armed, 0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alarm_bank.md
# alarm_bank

Parametrised multi-channel alarm engine. It replaces the single-alarm compare path in the watch's alarm mode. The block stores N_ALARM hour/minute alarm settings and compares them against the running time on every 1 Hz enable. It drives a ring request, the index of the ringing channel and a blinking LED bus, and supports acknowledge, snooze with a bounded count, and auto-stop. It sits between the time keeper, the alarm-set mode and the LED/display mux.

## Interface
- N_ALARM, 4: number of alarm channels (1..16); IW = max(1,$clog2(N_ALARM))
- SNOOZE_MIN, 5: snooze length in minutes (1..30)
- MAX_SNOOZE, 3: snoozes allowed per ring event; the next snooze is treated as ack
- RING_SEC, 60: auto-stop timeout in seconds (1..255)
- LED_W, 8: LED bus width
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- clk1sec  in  1  one-cycle 1 Hz enable
- hour  in  8  current hour, binary 0..23
- minute  in  8  current minute, binary 0..59
- second  in  8  current second, binary 0..59
- wr_en  in  1  one-cycle write strobe
- wr_idx  in  IW  channel to write
- wr_hour  in  8  alarm hour
- wr_min  in  8  alarm minute
- wr_arm  in  1  channel armed flag
- ack  in  1  one-cycle stop pulse (debounced)
- snooze  in  1  one-cycle snooze pulse (debounced)
- ring  out  1  some channel is RINGING
- ring_idx  out  IW  lowest-index RINGING channel
- armed  out  N_ALARM  per-channel armed flags
- led  out  LED_W  blink pattern

## Operation
- Per-channel registers: al_hour, al_min, al_arm, state {IDLE, RINGING, SNOOZED}, ring_cnt (8 bit), snz_cnt (width $clog2(SNOOZE_MIN*60+1)), snz_num ($clog2(MAX_SNOOZE+1)).
- Reset: every register is 0 and every channel is IDLE. Outputs are ring=0, ring_idx=0, armed=0, led=0.
- Write: when wr_en is high, channel wr_idx loads hour/min/arm. Its state is forced to IDLE and its counters are cleared. A wr_idx ≥ N_ALARM is ignored.
- Trigger (IDLE→RINGING): requires clk1sec=1, second==0, al_arm=1, hour==al_hour and minute==al_min. On trigger, ring_cnt is set to 0 and snz_num is set to 0.
- RINGING: ring_cnt increments on each clk1sec. When it reaches RING_SEC the channel goes to IDLE (missed alarm; armed stays set).
- ack and snooze act only on channel ring_idx:
  - ack: RINGING→IDLE.
  - snooze with snz_num<MAX_SNOOZE: RINGING→SNOOZED, snz_cnt=SNOOZE_MIN*60, snz_num+1.
  - snooze with snz_num==MAX_SNOOZE: acts as ack.
- SNOOZED: snz_cnt decrements on each clk1sec. The channel returns to RINGING with ring_cnt=0 on the clk1sec where snz_cnt reaches 0.
- If ack and snooze arrive together, ack wins.
- If wr_en and a trigger hit the same channel in the same cycle, the write wins and there is no ring.
- A matching time does not re-trigger a channel that is RINGING or SNOOZED.
- Several channels may ring at once. ring_idx is a priority encode of the lowest RINGING index.
- LED: a blink phase flop toggles on clk1sec while ring=1 and is cleared when ring=0. led is all ones when phase=1, otherwise 0.

## Timing
- All outputs are registered.
- ring and ring_idx rise 1 cycle after the clk1sec cycle that triggers.
- led first shows all ones 1 cycle after the next clk1sec following ring rising.
- ack/snooze: ring falls 1 cycle after the pulse, provided no other channel is ringing.
- armed follows wr_en with 1-cycle latency.
- A snoozed alarm re-rings exactly SNOOZE_MIN*60 clk1sec pulses after the snooze.
- Auto-stop: ring falls 1 cycle after the RING_SEC-th clk1sec after the trigger.
- Asserting rst mid-ring or mid-snooze clears everything immediately (asynchronously). No ring resumes after release.

## Test plan
- Program ch1=07:30 armed; sweep time through 07:30:00 with clk1sec -> ring=1, ring_idx=1 one cycle later. At 07:30:01 the channel does not re-trigger.
- Ring ch0, no ack -> ring stays 1 for 60 clk1sec pulses, then 0. led toggles every pulse during the ring, and led=0 after.
- Ring ch2, snooze 3 times (SNOOZE_MIN=1 for sim) -> re-ring after 60 pulses each time. The 4th snooze acts as ack: ring=0 and the channel does not re-ring.
- ch0 and ch3 both set to 12:00 -> ring_idx=0. ack -> ring_idx=3 and ring stays 1. A second ack -> ring=0.
- wr_en to ch1 in the same cycle as its trigger -> no ring. ack and snooze together while ringing -> IDLE, with no snooze.
- Assert rst while SNOOZED -> all outputs 0 immediately. After release, no ring until the registers are reprogrammed.
